accum_lanes: RTL and testbench

ACCUM_LANES -- requirements
Module: accum_lanes

---
 rtl/accum_pkg.sv | 21 ++
 rtl/accum_ofifo.sv | 56 +++++
 rtl/memory_block.sv | 26 ++
 rtl/accum_lanes.sv | 186 ++++++++++++++++++
 tb/tb_accum_lanes.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/accum_pkg.sv
// Shared helpers for the lane accumulator: saturation limits and output FIFO entry sizing.
package accum_pkg;

   localparam int unsigned SAT_MAXW = 64;

   function automatic logic [SAT_MAXW-1:0] sat_max(input int unsigned w);
      return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
   endfunction

   // Low w bits form the most negative w-bit value.
   function automatic logic [SAT_MAXW-1:0] sat_min(input int unsigned w);
      return ~sat_max(w);
   endfunction

   function automatic int unsigned ofifo_entry_w(input int unsigned lanes,
                                                 input int unsigned accw,
                                                 input int unsigned addrw);
      return lanes * accw + addrw;
   endfunction

endpackage

// File: rtl/accum_ofifo.sv
// Result FIFO for the lane accumulator; push and pop may coincide even when full.
module accum_ofifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTRW  = $clog2(DEPTH),
   localparam int unsigned CNTW  = PTRW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNTW-1:0]  count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNTW'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      if (do_push && !do_pop)      count_d = count_q + CNTW'(1);
      else if (!do_push && do_pop) count_d = count_q - CNTW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign valid = (count_q != '0);
   assign data  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/memory_block.sv
// Single-port-per-direction RAM: 1-cycle registered read, read returns pre-write data.
module memory_block #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 512,
   localparam int unsigned ADDRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rd_en,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [ADDRW-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/accum_lanes.sv
// Multi-lane read-modify-write accumulator with result forwarding and a buffered result stream.
module accum_lanes
   import accum_pkg::*;
#(
   parameter  int unsigned LANES       = 4,
   parameter  int unsigned DATAW       = 16,
   parameter  int unsigned ACCW        = 32,
   parameter  int unsigned DEPTH       = 512,
   parameter  int unsigned SAT         = 0,
   parameter  int unsigned OFIFO_DEPTH = 4,
   localparam int unsigned ADDRW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [LANES*DATAW-1:0] i_data,
   input  logic [ADDRW-1:0]       i_addr,
   input  logic                   i_accum,
   input  logic                   i_last,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [LANES*ACCW-1:0]  o_result,
   output logic [ADDRW-1:0]       o_addr
);

   localparam int unsigned ROWW = LANES * ACCW;
   localparam int unsigned ENTW = ofifo_entry_w(LANES, ACCW, ADDRW);
   localparam int unsigned CNTW = $clog2(OFIFO_DEPTH) + 1;
   localparam int unsigned OCCW = CNTW + 1;

   logic             accept;
   logic [ROWW-1:0]  rd_data;
   logic [ROWW-1:0]  operand;
   logic [ROWW-1:0]  sum;
   logic [CNTW-1:0]  fifo_count;
   logic [OCCW-1:0]  occ;
   logic [ENTW-1:0]  fifo_data;

   logic signed [ACCW-1:0] lane_a, lane_b, lane_res;
   logic signed [ACCW:0]   lane_sum;

   logic             s1_valid_q, s1_valid_d;
   logic [ADDRW-1:0] s1_addr_q,  s1_addr_d;
   logic [ROWW-1:0]  s1_data_q,  s1_data_d;
   logic             s1_accum_q, s1_accum_d;
   logic             s1_last_q,  s1_last_d;

   logic             s2_valid_q, s2_valid_d;
   logic [ADDRW-1:0] s2_addr_q,  s2_addr_d;
   logic [ROWW-1:0]  s2_sum_q,   s2_sum_d;
   logic             s2_last_q,  s2_last_d;

   logic             lw_valid_q, lw_valid_d;
   logic [ADDRW-1:0] lw_addr_q,  lw_addr_d;
   logic [ROWW-1:0]  lw_data_q,  lw_data_d;

   // Admission counts beats already in the pipe so every result has a FIFO slot.
   always_comb begin
      occ     = OCCW'(fifo_count) + OCCW'(s1_valid_q) + OCCW'(s2_valid_q);
      i_ready = rst && (occ < OCCW'(OFIFO_DEPTH));
      accept  = i_valid && i_ready;
   end

   // Stage 1: capture the beat with each lane sign-extended to accumulator width.
   always_comb begin
      s1_valid_d = accept;
      s1_addr_d  = s1_addr_q;
      s1_data_d  = s1_data_q;
      s1_accum_d = s1_accum_q;
      s1_last_d  = s1_last_q;
      if (accept) begin
         s1_addr_d  = i_addr;
         s1_accum_d = i_accum;
         s1_last_d  = i_last;
         for (int k = 0; k < LANES; k++)
            s1_data_d[k*ACCW +: ACCW] = ACCW'($signed(i_data[k*DATAW +: DATAW]));
      end
   end

   // Stage 2: pick the newest copy of the entry, then add per lane.
   always_comb begin
      operand  = rd_data;
      if (lw_valid_q && (lw_addr_q == s1_addr_q)) operand = lw_data_q;
      if (s2_valid_q && (s2_addr_q == s1_addr_q)) operand = s2_sum_q;
      if (!s1_accum_q) operand = '0;

      sum      = '0;
      lane_a   = '0;
      lane_b   = '0;
      lane_sum = '0;
      lane_res = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_a   = s1_data_q[k*ACCW +: ACCW];
         lane_b   = operand[k*ACCW +: ACCW];
         lane_sum = (ACCW+1)'(lane_a) + (ACCW+1)'(lane_b);
         lane_res = lane_sum[ACCW-1:0];
         if ((SAT != 0) && (lane_sum[ACCW] != lane_sum[ACCW-1]))
            lane_res = lane_sum[ACCW] ? ACCW'(sat_min(ACCW)) : ACCW'(sat_max(ACCW));
         sum[k*ACCW +: ACCW] = lane_res;
      end

      s2_valid_d = s1_valid_q;
      s2_addr_d  = s2_addr_q;
      s2_sum_d   = s2_sum_q;
      s2_last_d  = s2_last_q;
      if (s1_valid_q) begin
         s2_addr_d = s1_addr_q;
         s2_sum_d  = sum;
         s2_last_d = s1_last_q;
      end
   end

   // Last-written copy covers the read issued in the same cycle as the write.
   always_comb begin
      lw_valid_d = lw_valid_q;
      lw_addr_d  = lw_addr_q;
      lw_data_d  = lw_data_q;
      if (s2_valid_q) begin
         lw_valid_d = 1'b1;
         lw_addr_d  = s2_addr_q;
         lw_data_d  = s2_sum_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_data_q  <= '0;
         s1_accum_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_addr_q  <= '0;
         s2_sum_q   <= '0;
         s2_last_q  <= 1'b0;
         lw_valid_q <= 1'b0;
         lw_addr_q  <= '0;
         lw_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_data_q  <= s1_data_d;
         s1_accum_q <= s1_accum_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_addr_q  <= s2_addr_d;
         s2_sum_q   <= s2_sum_d;
         s2_last_q  <= s2_last_d;
         lw_valid_q <= lw_valid_d;
         lw_addr_q  <= lw_addr_d;
         lw_data_q  <= lw_data_d;
      end
   end

   memory_block #(
      .WIDTH (ROWW),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rd_en   (accept),
      .rd_addr (i_addr),
      .rd_data (rd_data),
      .wr_en   (s2_valid_q && rst),
      .wr_addr (s2_addr_q),
      .wr_data (s2_sum_q)
   );

   accum_ofifo #(
      .WIDTH (ENTW),
      .DEPTH (OFIFO_DEPTH)
   ) u_ofifo (
      .clk       (clk),
      .rst       (rst),
      .push      (s2_valid_q && s2_last_q),
      .push_data ({s2_addr_q, s2_sum_q}),
      .pop       (o_ready),
      .valid     (o_valid),
      .data      (fifo_data),
      .count     (fifo_count)
   );

   assign o_addr   = fifo_data[ENTW-1 -: ADDRW];
   assign o_result = fifo_data[ROWW-1:0];

endmodule

// File: tb/tb_accum_lanes.sv
// Directed bench for accum_lanes: vector table plus forwarding, backpressure and reset sequences.
module tb_accum_lanes;

   localparam int unsigned DEPTH = 512;
   localparam int unsigned OFD   = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         i_valid = 1'b0;
   logic         i_accum = 1'b0;
   logic         i_last = 1'b0;
   logic         o_ready = 1'b1;
   logic [63:0]  i_data = '0;
   logic [8:0]   i_addr = '0;

   logic         i_ready, o_valid, i_ready_s, o_valid_s, i_ready_w, o_valid_w;
   logic [127:0] o_result;
   logic [63:0]  o_result_s, o_result_w;
   logic [8:0]   o_addr, o_addr_s, o_addr_w;

   int checks = 0;
   int errors = 0;
   int acc_tot = 0;

   always #5 clk = ~clk;

   accum_lanes dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .i_addr(i_addr), .i_accum(i_accum), .i_last(i_last), .o_valid(o_valid),
      .o_ready(o_ready), .o_result(o_result), .o_addr(o_addr)
   );

   accum_lanes #(.ACCW(16), .SAT(1)) dut_sat (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_s), .i_data(i_data),
      .i_addr(i_addr), .i_accum(i_accum), .i_last(i_last), .o_valid(o_valid_s),
      .o_ready(o_ready), .o_result(o_result_s), .o_addr(o_addr_s)
   );

   accum_lanes #(.ACCW(16), .SAT(0)) dut_wrap (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready_w), .i_data(i_data),
      .i_addr(i_addr), .i_accum(i_accum), .i_last(i_last), .o_valid(o_valid_w),
      .o_ready(o_ready), .o_result(o_result_w), .o_addr(o_addr_w)
   );

   always @(posedge clk) begin
      if (rst && i_valid && i_ready) acc_tot <= acc_tot + 1;
      if (rst && i_valid) assert (int'(i_addr) < int'(DEPTH)) else $error("illegal address %0d", i_addr);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [8:0]   addr;
      logic [63:0]  data;
      logic         acc;
      logic         last;
      logic [127:0] exp;
      logic         ovf;
      logic [63:0]  exp_s;
      logic [63:0]  exp_w;
   } vec_t;

   vec_t vt [11];

   function automatic logic [63:0] d4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [127:0] r4(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [63:0] t16(input logic [127:0] r);
      logic [63:0] t;
      t = '0;
      for (int k = 0; k < 4; k++) t[k*16 +: 16] = r[k*32 +: 16];
      return t;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one beat at a negedge, hold until accepted, return at the following negedge.
   task automatic send(input logic [8:0] addr, input logic [63:0] data, input logic acc, input logic last);
      int n = 0;
      i_valid = 1'b1;
      i_addr  = addr;
      i_data  = data;
      i_accum = acc;
      i_last  = last;
      while (!i_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!i_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: i_ready low for addr %0d", addr);
      end else begin
         @(negedge clk);
      end
      i_valid = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [8:0] addr, input logic [127:0] res,
                             input logic [63:0] rs, input logic [63:0] rw);
      int n = 0;
      while (!o_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_valid"}, 128'(o_valid), 128'(1'b1));
      if (o_valid) begin
         chk({name, "_addr"}, 128'(o_addr), 128'(addr));
         chk({name, "_result"}, o_result, res);
         chk({name, "_sub_valid"}, 128'({o_valid_s, o_valid_w}), 128'(2'b11));
         chk({name, "_sub_addr"}, 128'({o_addr_s, o_addr_w}), 128'({addr, addr}));
         chk({name, "_sat"}, 128'(o_result_s), 128'(rs));
         chk({name, "_wrap"}, 128'(o_result_w), 128'(rw));
         if (o_ready) @(negedge clk);
      end
   endtask

   initial begin
      int base;

      vt[0]  = '{9'd5,   d4(1, 2, 3, 4),           1'b0, 1'b0, '0, 1'b0, '0, '0};
      vt[1]  = '{9'd5,   d4(10, 20, 30, 40),       1'b1, 1'b1, r4(11, 22, 33, 44), 1'b0, '0, '0};
      vt[2]  = '{9'd9,   d4(-5, -5, -5, -5),       1'b0, 1'b0, '0, 1'b0, '0, '0};
      vt[3]  = '{9'd9,   d4(3, 3, 3, 3),           1'b1, 1'b1, r4(-2, -2, -2, -2), 1'b0, '0, '0};
      vt[4]  = '{9'd0,   d4(100, -100, 32767, -32768), 1'b0, 1'b1,
                 r4(100, -100, 32767, -32768), 1'b0, '0, '0};
      vt[5]  = '{9'd511, d4(1, 1, 1, 1),           1'b0, 1'b0, '0, 1'b0, '0, '0};
      vt[6]  = '{9'd511, d4(2, 3, 4, 5),           1'b1, 1'b1, r4(3, 4, 5, 6), 1'b0, '0, '0};
      vt[7]  = '{9'd5,   d4(1, 1, 1, 1),           1'b1, 1'b1, r4(12, 23, 34, 45), 1'b0, '0, '0};
      vt[8]  = '{9'd5,   d4(7, -7, 0, 1),          1'b0, 1'b1, r4(7, -7, 0, 1), 1'b0, '0, '0};
      vt[9]  = '{9'd3,   d4(32'h7FF0, -32752, 0, 1), 1'b0, 1'b0, '0, 1'b0, '0, '0};
      vt[10] = '{9'd3,   d4(32'h0020, -32, 5, -1), 1'b1, 1'b1,
                 r4(32'h8010, -32784, 5, 0), 1'b1,
                 {16'h0000, 16'h0005, 16'h8000, 16'h7FFF},
                 {16'h0000, 16'h0005, 16'h7FF0, 16'h8010}};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_o_valid", 128'(o_valid), 128'(1'b0));
      chk("rst_i_ready", 128'({i_ready, i_ready_s, i_ready_w}), 128'(3'b000));
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_i_ready", 128'({i_ready, i_ready_s, i_ready_w}), 128'(3'b111));
      chk("post_rst_o_valid", 128'(o_valid), 128'(1'b0));

      for (int i = 0; i < 11; i++) begin
         send(vt[i].addr, vt[i].data, vt[i].acc, vt[i].last);
         if (vt[i].last)
            expect_out($sformatf("vec%0d", i), vt[i].addr, vt[i].exp,
                       vt[i].ovf ? vt[i].exp_s : t16(vt[i].exp),
                       vt[i].ovf ? vt[i].exp_w : t16(vt[i].exp));
      end

      // Earliest output is the third cycle after acceptance
      send(9'd20, d4(1, 2, 3, 4), 1'b0, 1'b1);
      chk("lat_t1", 128'(o_valid), 128'(1'b0));
      @(negedge clk);
      chk("lat_t2", 128'(o_valid), 128'(1'b0));
      @(negedge clk);
      chk("lat_t3", 128'(o_valid), 128'(1'b1));
      expect_out("lat", 9'd20, r4(1, 2, 3, 4), t16(r4(1, 2, 3, 4)), t16(r4(1, 2, 3, 4)));

      // Back-to-back same address
      send(9'd7, d4(1, 1, 1, 1), 1'b0, 1'b0);
      send(9'd7, d4(1, 1, 1, 1), 1'b1, 1'b0);
      send(9'd7, d4(1, 1, 1, 1), 1'b1, 1'b1);
      expect_out("fwd3", 9'd7, r4(3, 3, 3, 3), t16(r4(3, 3, 3, 3)), t16(r4(3, 3, 3, 3)));

      // One-cycle gap
      send(9'd8, d4(5, 6, 7, 8), 1'b0, 1'b0);
      @(negedge clk);
      send(9'd8, d4(1, 1, 1, 1), 1'b1, 1'b1);
      expect_out("gap1", 9'd8, r4(6, 7, 8, 9), t16(r4(6, 7, 8, 9)), t16(r4(6, 7, 8, 9)));

      // Two-cycle gap
      send(9'd10, d4(100, 200, 300, 400), 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      send(9'd10, d4(-1, -2, -3, -4), 1'b1, 1'b1);
      expect_out("gap2", 9'd10, r4(99, 198, 297, 396), t16(r4(99, 198, 297, 396)),
                 t16(r4(99, 198, 297, 396)));

      // Interleaved addresses
      send(9'd11, d4(1, 1, 1, 1), 1'b0, 1'b0);
      send(9'd12, d4(2, 2, 2, 2), 1'b0, 1'b0);
      send(9'd11, d4(10, 10, 10, 10), 1'b1, 1'b1);
      expect_out("inter", 9'd11, r4(11, 11, 11, 11), t16(r4(11, 11, 11, 11)),
                 t16(r4(11, 11, 11, 11)));

      // Output backpressure
      o_ready = 1'b0;
      base = acc_tot;
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(9'(30 + i), d4(i + 1, i + 2, i + 3, i + 4), 1'b0, 1'b1);
         end
         begin
            repeat (20) @(negedge clk);
            chk("bp_accepted", 128'(acc_tot - base), 128'(OFD));
            chk("bp_i_ready", 128'(i_ready), 128'(1'b0));
            chk("bp_o_valid", 128'(o_valid), 128'(1'b1));
            chk("bp_o_addr", 128'(o_addr), 128'(9'd30));
            chk("bp_stable", o_result, r4(1, 2, 3, 4));
            o_ready = 1'b1;
            for (int j = 0; j < 10; j++)
               expect_out($sformatf("bp%0d", j), 9'(30 + j), r4(j + 1, j + 2, j + 3, j + 4),
                          t16(r4(j + 1, j + 2, j + 3, j + 4)), t16(r4(j + 1, j + 2, j + 3, j + 4)));
         end
      join

      // Reset with two beats in flight
      send(9'd40, d4(1, 1, 1, 1), 1'b0, 1'b1);
      send(9'd41, d4(2, 2, 2, 2), 1'b0, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_o_valid", 128'(o_valid), 128'(1'b0));
      chk("mid_rst_i_ready", 128'(i_ready), 128'(1'b0));
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("mid_rst_quiet%0d", i), 128'({o_valid, o_valid_s, o_valid_w}), 128'(3'b000));
      end
      chk("mid_rst_i_ready_after", 128'(i_ready), 128'(1'b1));

      send(9'd42, d4(9, 9, 9, 9), 1'b0, 1'b1);
      expect_out("resume", 9'd42, r4(9, 9, 9, 9), t16(r4(9, 9, 9, 9)), t16(r4(9, 9, 9, 9)));

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
